renametable_ckpt: RTL and testbench

- Parametrised speculative register alias table (RAT) for the rename stage.
- Supports RENAME_WIDTH lanes per cycle with intra-group bypass, youngest-lane write priority, and a committed (architectural) RAT.
- Holds NUM_CKPT snapshot slots for branch recovery, plus full flush-restore from the committed RAT.
- Sits between decode and rename/dispatch; commit-side updates arrive from the ROB.

---
 rtl/renametable_ckpt_if.sv | 51 +++++
 rtl/renametable_ckpt.sv | 121 ++++++++++++
 tb/tb_renametable_ckpt.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/renametable_ckpt_if.sv
// renametable_ckpt_if: rename-stage bus for the RAT: lane reads, rename/commit writes, checkpoint control.
interface renametable_ckpt_if #(
    parameter int RENAME_WIDTH = 2,
    parameter int PREG_WIDTH   = 6,
    parameter int NUM_CKPT     = 4,
    parameter int CKPT_ID_W    = $clog2(NUM_CKPT)
);
    logic [RENAME_WIDTH-1:0]            src1_is_reg;
    logic [5*RENAME_WIDTH-1:0]          rs1;
    logic [RENAME_WIDTH-1:0]            src2_is_reg;
    logic [5*RENAME_WIDTH-1:0]          rs2;
    logic [RENAME_WIDTH-1:0]            need_to_wb;
    logic [5*RENAME_WIDTH-1:0]          rd;
    logic [PREG_WIDTH*RENAME_WIDTH-1:0] rat_prs1;
    logic [PREG_WIDTH*RENAME_WIDTH-1:0] rat_prs2;
    logic [PREG_WIDTH*RENAME_WIDTH-1:0] rat_prd;
    logic [RENAME_WIDTH-1:0]            rename_valid;
    logic [5*RENAME_WIDTH-1:0]          rename_addr;
    logic [PREG_WIDTH*RENAME_WIDTH-1:0] rename_data;
    logic                               ckpt_req;
    logic                               ckpt_ack;
    logic [CKPT_ID_W-1:0]               ckpt_id;
    logic                               ckpt_full;
    logic                               ckpt_release_valid;
    logic [CKPT_ID_W-1:0]               ckpt_release_id;
    logic                               recover_valid;
    logic [CKPT_ID_W-1:0]               recover_id;
    logic [NUM_CKPT-1:0]                recover_free_mask;
    logic [RENAME_WIDTH-1:0]            commit_valid;
    logic [5*RENAME_WIDTH-1:0]          commit_areg;
    logic [PREG_WIDTH*RENAME_WIDTH-1:0] commit_preg;
    logic                               flush_valid;

    modport master (
        output src1_is_reg, rs1, src2_is_reg, rs2, need_to_wb, rd,
        output rename_valid, rename_addr, rename_data,
        output ckpt_req, ckpt_release_valid, ckpt_release_id,
        output recover_valid, recover_id, recover_free_mask,
        output commit_valid, commit_areg, commit_preg, flush_valid,
        input  rat_prs1, rat_prs2, rat_prd, ckpt_ack, ckpt_id, ckpt_full
    );

    modport slave (
        input  src1_is_reg, rs1, src2_is_reg, rs2, need_to_wb, rd,
        input  rename_valid, rename_addr, rename_data,
        input  ckpt_req, ckpt_release_valid, ckpt_release_id,
        input  recover_valid, recover_id, recover_free_mask,
        input  commit_valid, commit_areg, commit_preg, flush_valid,
        output rat_prs1, rat_prs2, rat_prd, ckpt_ack, ckpt_id, ckpt_full
    );
endinterface

// File: rtl/renametable_ckpt.sv
// renametable_ckpt: speculative RAT with intra-group bypass, committed RAT and snapshot slots.
// Define RAT_ZERO_PIN_EN to hard-wire areg 0 to preg 0.
module renametable_ckpt #(
    parameter int RENAME_WIDTH = 2,
    parameter int PREG_WIDTH   = 6,
    parameter int NUM_CKPT     = 4,
    parameter int CKPT_ID_W    = $clog2(NUM_CKPT)
) (
    input logic clock,
    input logic reset,
    renametable_ckpt_if.slave bus
);
    localparam int RW = RENAME_WIDTH;
    localparam int PW = PREG_WIDTH;
`ifdef RAT_ZERO_PIN_EN
    localparam bit ZERO_PIN = 1'b1;
`else
    localparam bit ZERO_PIN = 1'b0;
`endif

    logic [PW-1:0]        spec_rat [32];
    logic [PW-1:0]        comm_rat [32];
    logic [PW-1:0]        snap     [NUM_CKPT][32];
    logic [NUM_CKPT-1:0]  busy;
    logic [PW-1:0]        spec_upd [32];
    logic [PW-1:0]        comm_upd [32];
    logic [PW-1:0]        spec_nxt [32];
    logic [NUM_CKPT-1:0]  busy_nxt;
    logic [CKPT_ID_W-1:0] free_id;
    logic                 full;
    logic                 ack;
    logic [PW*RW-1:0]     prs1;
    logic [PW*RW-1:0]     prs2;
    logic [PW*RW-1:0]     prd;

    // Later older lanes overwrite earlier ones, so the youngest older writer wins.
    always_comb begin
        prs1 = '0;
        prs2 = '0;
        prd  = '0;
        for (int k = 0; k < RW; k++) begin
            logic [4:0]    a1, a2, ad;
            logic [PW-1:0] p1, p2, pd;
            a1 = bus.rs1[5*k+:5];
            a2 = bus.rs2[5*k+:5];
            ad = bus.rd[5*k+:5];
            p1 = spec_rat[a1];
            p2 = spec_rat[a2];
            pd = spec_rat[ad];
            for (int i = 0; i < k; i++) begin
                p1 = (bus.rename_valid[i] && bus.rename_addr[5*i+:5] == a1) ? bus.rename_data[PW*i+:PW] : p1;
                p2 = (bus.rename_valid[i] && bus.rename_addr[5*i+:5] == a2) ? bus.rename_data[PW*i+:PW] : p2;
                pd = (bus.rename_valid[i] && bus.rename_addr[5*i+:5] == ad) ? bus.rename_data[PW*i+:PW] : pd;
            end
            prs1[PW*k+:PW] = (bus.src1_is_reg[k] && !(ZERO_PIN && a1 == 5'd0)) ? p1 : '0;
            prs2[PW*k+:PW] = (bus.src2_is_reg[k] && !(ZERO_PIN && a2 == 5'd0)) ? p2 : '0;
            prd[PW*k+:PW]  = (bus.need_to_wb[k]  && !(ZERO_PIN && ad == 5'd0)) ? pd : '0;
        end
    end

    always_comb begin
        spec_upd = spec_rat;
        comm_upd = comm_rat;
        for (int i = 0; i < RW; i++) begin
            if (bus.rename_valid[i] && !(ZERO_PIN && bus.rename_addr[5*i+:5] == 5'd0))
                spec_upd[bus.rename_addr[5*i+:5]] = bus.rename_data[PW*i+:PW];
            if (bus.commit_valid[i] && !(ZERO_PIN && bus.commit_areg[5*i+:5] == 5'd0))
                comm_upd[bus.commit_areg[5*i+:5]] = bus.commit_preg[PW*i+:PW];
        end
        for (int a = 0; a < 32; a++)
            spec_nxt[a] = bus.flush_valid ? comm_upd[a] : bus.recover_valid ? snap[bus.recover_id][a] : spec_upd[a];
    end

    assign full = &busy;
    assign ack  = bus.ckpt_req & ~full & ~bus.flush_valid & ~bus.recover_valid & ~reset;

    // Allocation looks at the registered busy vector, so a same-cycle release is not yet allocatable.
    always_comb begin
        free_id  = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--)
            free_id = busy[i] ? free_id : CKPT_ID_W'(i);
        busy_nxt = busy;
        if (bus.ckpt_release_valid)
            busy_nxt[bus.ckpt_release_id] = 1'b0;
        if (bus.flush_valid)
            busy_nxt = '0;
        else if (bus.recover_valid)
            busy_nxt = busy_nxt & ~bus.recover_free_mask;
        if (ack)
            busy_nxt[free_id] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < 32; a++) begin
                spec_rat[a] <= PW'(a);
                comm_rat[a] <= PW'(a);
            end
            for (int c = 0; c < NUM_CKPT; c++)
                for (int a = 0; a < 32; a++)
                    snap[c][a] <= PW'(a);
            busy <= '0;
        end else begin
            for (int a = 0; a < 32; a++) begin
                spec_rat[a] <= spec_nxt[a];
                comm_rat[a] <= comm_upd[a];
            end
            if (ack)
                for (int a = 0; a < 32; a++)
                    snap[free_id][a] <= spec_upd[a];
            busy <= busy_nxt;
        end
    end

    assign bus.rat_prs1  = prs1;
    assign bus.rat_prs2  = prs2;
    assign bus.rat_prd   = prd;
    assign bus.ckpt_ack  = ack;
    assign bus.ckpt_id   = free_id;
    assign bus.ckpt_full = full;
endmodule

// File: tb/tb_renametable_ckpt.sv
// tb_renametable_ckpt: directed vectors with a table-level RAT model checked every cycle.
module tb_renametable_ckpt;
    localparam int RW = 2;
    localparam int PW = 6;
    localparam int NC = 4;
    localparam int IW = 2;
`ifdef RAT_ZERO_PIN_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    renametable_ckpt_if #(.RENAME_WIDTH(RW), .PREG_WIDTH(PW), .NUM_CKPT(NC), .CKPT_ID_W(IW)) bus ();
    renametable_ckpt #(.RENAME_WIDTH(RW), .PREG_WIDTH(PW), .NUM_CKPT(NC), .CKPT_ID_W(IW)) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    logic [PW-1:0] m_spec [32];
    logic [PW-1:0] m_comm [32];
    logic [PW-1:0] m_snap [NC][32];
    bit            m_busy [NC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int m_free();
        for (int i = 0; i < NC; i++)
            if (!m_busy[i]) return i;
        return 0;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < NC; i++)
            if (!m_busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ack();
        return bus.ckpt_req && !m_full() && !bus.flush_valid && !bus.recover_valid;
    endfunction

    // Search from the nearest older lane backwards; first hit is the youngest older writer.
    function automatic logic [PW-1:0] m_read(input logic en, input logic [4:0] a, input int k);
        if (!en || (ZP && a == 5'd0)) return '0;
        for (int i = k - 1; i >= 0; i--)
            if (bus.rename_valid[i] && bus.rename_addr[5*i+:5] == a) return bus.rename_data[PW*i+:PW];
        return m_spec[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [PW-1:0] ns [32];
        logic [PW-1:0] nc [32];
        int id;
        bit ak;
        if (rst) begin
            for (int a = 0; a < 32; a++) begin
                m_spec[a] = PW'(a);
                m_comm[a] = PW'(a);
                for (int c = 0; c < NC; c++) m_snap[c][a] = PW'(a);
            end
            for (int c = 0; c < NC; c++) m_busy[c] = 1'b0;
        end else begin
            ak = m_ack();
            id = m_free();
            ns = m_spec;
            nc = m_comm;
            for (int i = 0; i < RW; i++) begin
                if (bus.rename_valid[i] && !(ZP && bus.rename_addr[5*i+:5] == 5'd0))
                    ns[bus.rename_addr[5*i+:5]] = bus.rename_data[PW*i+:PW];
                if (bus.commit_valid[i] && !(ZP && bus.commit_areg[5*i+:5] == 5'd0))
                    nc[bus.commit_areg[5*i+:5]] = bus.commit_preg[PW*i+:PW];
            end
            if (bus.flush_valid) begin
                m_spec = nc;
                for (int c = 0; c < NC; c++) m_busy[c] = 1'b0;
            end else if (bus.recover_valid) begin
                m_spec = m_snap[bus.recover_id];
                for (int c = 0; c < NC; c++) if (bus.recover_free_mask[c]) m_busy[c] = 1'b0;
            end else begin
                m_spec = ns;
            end
            if (bus.ckpt_release_valid) m_busy[bus.ckpt_release_id] = 1'b0;
            if (ak) begin
                m_busy[id] = 1'b1;
                m_snap[id] = ns;
            end
            m_comm = nc;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < RW; k++) begin
                chk($sformatf("m_prs1[%0d]", k), 32'(bus.rat_prs1[PW*k+:PW]), 32'(m_read(bus.src1_is_reg[k], bus.rs1[5*k+:5], k)));
                chk($sformatf("m_prs2[%0d]", k), 32'(bus.rat_prs2[PW*k+:PW]), 32'(m_read(bus.src2_is_reg[k], bus.rs2[5*k+:5], k)));
                chk($sformatf("m_prd[%0d]", k), 32'(bus.rat_prd[PW*k+:PW]), 32'(m_read(bus.need_to_wb[k], bus.rd[5*k+:5], k)));
            end
            chk("m_ack", 32'(bus.ckpt_ack), 32'(m_ack()));
            chk("m_full", 32'(bus.ckpt_full), 32'(m_full()));
            chk("m_id", 32'(bus.ckpt_id), 32'(m_free()));
        end
    end

    task automatic clr();
        bus.src1_is_reg = '0; bus.rs1 = '0; bus.src2_is_reg = '0; bus.rs2 = '0;
        bus.need_to_wb = '0; bus.rd = '0;
        bus.rename_valid = '0; bus.rename_addr = '0; bus.rename_data = '0;
        bus.ckpt_req = 1'b0; bus.ckpt_release_valid = 1'b0; bus.ckpt_release_id = '0;
        bus.recover_valid = 1'b0; bus.recover_id = '0; bus.recover_free_mask = '0;
        bus.commit_valid = '0; bus.commit_areg = '0; bus.commit_preg = '0;
        bus.flush_valid = 1'b0;
    endtask

    task automatic lane(input int k, input bit v1, input int r1, input bit v2, input int r2, input bit vd, input int d);
        bus.src1_is_reg[k] = v1; bus.rs1[5*k+:5] = 5'(r1);
        bus.src2_is_reg[k] = v2; bus.rs2[5*k+:5] = 5'(r2);
        bus.need_to_wb[k] = vd;  bus.rd[5*k+:5]  = 5'(d);
    endtask

    task automatic ren(input int k, input int a, input int p);
        bus.rename_valid[k] = 1'b1; bus.rename_addr[5*k+:5] = 5'(a); bus.rename_data[PW*k+:PW] = PW'(p);
    endtask

    task automatic com(input int k, input int a, input int p);
        bus.commit_valid[k] = 1'b1; bus.commit_areg[5*k+:5] = 5'(a); bus.commit_preg[PW*k+:PW] = PW'(p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        rst = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // reset state
        lane(0, 1, 5, 0, 0, 0, 9); lane(1, 0, 0, 1, 31, 0, 0);
        @(negedge clk);
        chk("rst_prs1", 32'(bus.rat_prs1[0+:PW]), 5);
        chk("rst_prs2", 32'(bus.rat_prs2[PW+:PW]), 31);
        chk("rst_prd_gated", 32'(bus.rat_prd[0+:PW]), 0);
        chk("rst_full", 32'(bus.ckpt_full), 0);
        chk("rst_id", 32'(bus.ckpt_id), 0);
        step();
        // intra-group bypass and youngest-wins
        lane(0, 1, 3, 0, 0, 0, 0); lane(1, 1, 3, 0, 0, 0, 0);
        ren(0, 3, 40); ren(1, 3, 41);
        @(negedge clk);
        chk("byp_l0", 32'(bus.rat_prs1[0+:PW]), 3);
        chk("byp_l1", 32'(bus.rat_prs1[PW+:PW]), 40);
        step();
        lane(0, 1, 3, 0, 0, 0, 0); lane(1, 0, 0, 0, 0, 1, 3);
        @(negedge clk);
        chk("ywin_x3", 32'(bus.rat_prs1[0+:PW]), 41);
        chk("ywin_prd", 32'(bus.rat_prd[PW+:PW]), 41);
        step();
        // checkpoint then recover
        bus.ckpt_req = 1'b1; ren(0, 7, 50); lane(0, 1, 7, 0, 0, 0, 0);
        @(negedge clk);
        chk("ck_ack", 32'(bus.ckpt_ack), 1);
        chk("ck_id", 32'(bus.ckpt_id), 0);
        chk("ck_noself", 32'(bus.rat_prs1[0+:PW]), 7);
        step();
        ren(0, 7, 51);
        @(negedge clk);
        chk("ck_next_id", 32'(bus.ckpt_id), 1);
        step();
        bus.recover_valid = 1'b1; bus.recover_id = 2'd0; bus.recover_free_mask = 4'b0001;
        bus.ckpt_req = 1'b1; ren(0, 7, 52); lane(0, 1, 7, 0, 0, 0, 0); lane(1, 1, 7, 0, 0, 0, 0);
        @(negedge clk);
        chk("rec_ack0", 32'(bus.ckpt_ack), 0);
        chk("rec_rd", 32'(bus.rat_prs1[0+:PW]), 51);
        step();
        lane(0, 1, 7, 0, 0, 0, 0);
        @(negedge clk);
        chk("rec_x7", 32'(bus.rat_prs1[0+:PW]), 50);
        chk("rec_free", 32'(bus.ckpt_id), 0);
        step();
        // fill all slots
        for (int n = 0; n < 4; n++) begin
            bus.ckpt_req = 1'b1;
            @(negedge clk);
            chk($sformatf("fill_ack%0d", n), 32'(bus.ckpt_ack), 1);
            chk($sformatf("fill_id%0d", n), 32'(bus.ckpt_id), 32'(n));
            step();
        end
        bus.ckpt_req = 1'b1;
        @(negedge clk);
        chk("full_flag", 32'(bus.ckpt_full), 1);
        chk("full_ack", 32'(bus.ckpt_ack), 0);
        step();
        bus.ckpt_req = 1'b1; bus.ckpt_release_valid = 1'b1; bus.ckpt_release_id = 2'd2;
        @(negedge clk);
        chk("rel_same_ack", 32'(bus.ckpt_ack), 0);
        step();
        bus.ckpt_req = 1'b1;
        @(negedge clk);
        chk("rel_ack", 32'(bus.ckpt_ack), 1);
        chk("rel_id", 32'(bus.ckpt_id), 2);
        step();
        // commit then flush
        com(0, 9, 60);
        step();
        com(0, 11, 20); com(1, 11, 21);
        step();
        bus.flush_valid = 1'b1; ren(0, 9, 61); com(1, 10, 62); bus.ckpt_req = 1'b1;
        @(negedge clk);
        chk("fl_ack", 32'(bus.ckpt_ack), 0);
        step();
        lane(0, 1, 9, 1, 11, 0, 0); lane(1, 1, 10, 0, 0, 1, 3);
        bus.ckpt_release_valid = 1'b1; bus.ckpt_release_id = 2'd3;
        @(negedge clk);
        chk("fl_x9", 32'(bus.rat_prs1[0+:PW]), 60);
        chk("fl_x10", 32'(bus.rat_prs1[PW+:PW]), 62);
        chk("fl_x11", 32'(bus.rat_prs2[0+:PW]), 21);
        chk("fl_x3", 32'(bus.rat_prd[PW+:PW]), 3);
        chk("fl_full", 32'(bus.ckpt_full), 0);
        step();
        bus.ckpt_req = 1'b1;
        @(negedge clk);
        chk("free_rel_ack", 32'(bus.ckpt_ack), 1);
        chk("free_rel_id", 32'(bus.ckpt_id), 0);
        step();
        // x0 behaviour
        ren(0, 0, 33);
        step();
        lane(0, 1, 0, 0, 0, 0, 0); lane(1, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("x0_read", 32'(bus.rat_prs1[0+:PW]), ZP ? 0 : 33);
        chk("x0_read_l1", 32'(bus.rat_prs2[PW+:PW]), ZP ? 0 : 33);
        step();
        // asynchronous reset mid-operation with a request held
        bus.ckpt_req = 1'b1; lane(0, 1, 9, 0, 0, 0, 0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mrst_ack", 32'(bus.ckpt_ack), 0);
        chk("mrst_full", 32'(bus.ckpt_full), 0);
        chk("mrst_id", 32'(bus.ckpt_id), 0);
        chk("mrst_x9", 32'(bus.rat_prs1[0+:PW]), 9);
        @(posedge clk);
        #1 rst = 1'b0;
        clr();
        lane(0, 1, 0, 0, 0, 0, 0); lane(1, 1, 3, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_x0", 32'(bus.rat_prs1[0+:PW]), 0);
        chk("post_x3", 32'(bus.rat_prs1[PW+:PW]), 3);
        step();
        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
